sequence_ctrl: RTL and testbench
================================

# sequence_ctrl

Hardwired control unit for the Mini SRC datapath. It issues every datapath control strobe: bus source select, register enables, select-and-encode lines, ALU op, RAM strobes and PC controls. It steps the datapath through instruction fetch, decode and execute for a subset of the ISA, replacing hand-written per-instruction strobe sequences. It sits beside `datapath` and drives all of its control inputs; it sees only the IR and the CON flip-flop.

## Interface
- No parameters.
- clock  in  1  rising-edge clock.
- clear  in  1  asynchronous, active-low reset; 0 forces IDLE.
- start  in  1  level; leaves IDLE or HALTED and begins fetching at the current PC.
- ir  in  32  IR contents from datapath; opcode = ir[31:27].
- con_ff  in  1  CON flip-flop output from datapath.
- incPC, e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR, e_MAR, e_OutPort, e_InPort, e_RA, e_CON_FF  out  1 each  datapath enables.
- ram_read, ram_write, MDR_read  out  1 each  memory strobes; MDR_read=1 selects memory into MDR, 0 selects bus.
- Gra, Grb, Grc, e_Rin, e_Rout, BAout, imm_sel  out  1 each  select/encode and operand mux.
- ALU_op  out  4  ALU operation.
- BusDataSelect  out  5  bus source.
- run  out  1  high in any state except IDLE and HALTED.
- illegal  out  1  one-cycle pulse in DEC when the opcode is unsupported.

## Operation
- Bus codes: 00000 none/R0 via BAout; 00001 register file (e_Rout); 10011 Zlow; 10100 PC; 10101 MDR; 11000 C (sign-extended).
- Every state lasts one cycle. Outputs are a combinational function of the state, plus ir for ALU_op and con_ff for branch e_PC. The datapath captures on the closing edge. Any strobe not listed for a state is 0.
- IDLE: all outputs 0. Goes to F0 when start=1.
- Fetch:
  - F0: BDS=PC, e_MAR, incPC.
  - F1: ram_read.
  - F2: MDR_read, e_MDR.
  - F3: BDS=MDR, e_IR.
  - DEC: no strobes; dispatches on ir[31:27].
- Supported opcodes:
  - ld 00000, ldi 00001, st 00010.
  - R-type 00011–01011 (add, sub, and, or, ror, rol, shr, shra, shl).
  - addi 01100, andi 01101, ori 01110.
  - br 10011, jr 10100, nop 11010, halt 11011.
- Any other opcode: illegal=1, then DEC→F0.
- ALU_op: ir[30:27] for R-type; 0011 for ld/ldi/st/addi/br; 0101 for andi; 0110 for ori.
- R-type:
  - E3: Grb, e_Rout, BDS=REG, e_Y.
  - E4: Grc, e_Rout, BDS=REG, e_Z.
  - E5: Gra, e_Rin, BDS=Zlow.
  - Then F0.
- addi/andi/ori: same as R-type, except E4 uses imm_sel instead of Grc/e_Rout.
- ldi: E3 uses Grb, BAout, BDS=none, e_Y; E4 imm_sel, e_Z; E5 as R-type.
- ld:
  - E3 and E4 as ldi.
  - E5: BDS=Zlow, e_MAR.
  - E6: ram_read.
  - E7: MDR_read, e_MDR.
  - E8: BDS=MDR, Gra, e_Rin.
- st:
  - E3–E5 as ld.
  - E6: Gra, e_Rout, BDS=REG, e_MDR, MDR_read=0.
  - E7: ram_write.
- br:
  - E3: Gra, e_Rout, BDS=REG, e_CON_FF.
  - E4: BDS=PC, e_Y.
  - E5: imm_sel, e_Z.
  - E6: BDS=Zlow, e_PC=con_ff.
- jr: E3: Gra, e_Rout, BDS=REG, e_PC.
- nop: DEC→F0.
- halt: DEC→HALTED. HALTED has all outputs 0 and run=0; goes to F0 on start=1.
- The last execute state of every instruction goes to F0. start is ignored outside IDLE and HALTED.

## Timing
- Reset (clear=0, async): state=IDLE; every output 0, including ALU_op=0000, BusDataSelect=00000, run=0, illegal=0.
- Reset mid-instruction aborts immediately; no strobe survives into the reset cycle.
- Release of reset is synchronous to the next rising edge.
- Cycles per instruction, F0 through last execute state inclusive:
  - nop: 5.
  - jr: 6.
  - R-type, imm, ldi: 8.
  - br: 9.
  - st: 10.
  - ld: 11.
- run rises in the cycle after start is sampled.
- con_ff is registered at the end of br E3 and is stable by E6.
- At most one BDS source and at most one of e_Rin/e_Rout are asserted per cycle.
- ram_read and ram_write are never high together.

## Test plan
- Reset mid-F2 (clear=0 for 1 ns), then release: all outputs 0 immediately, run=0, IDLE held until start.
- Program ldi R2,0x78 then halt at PC 0: R2=0x00000078; run falls 13 cycles after the first F0; PC=2.
- ldi R2,0x10; st R2,0x20(R2): mem[0x30]=0x10; ram_write high for exactly 1 cycle.
- ldi R2,0x05; ld R6,0x63(R2) with mem[0x68]=0xDEAD: R6=0x0000DEAD after 11 ld cycles.
- brzr R2,+4 with R2=0: PC=PC_br+1+4. Same with R2=1: PC=PC_br+1; e_PC=0 in E6.
- Opcode 11111: illegal pulses for 1 cycle in DEC; no register writes; fetch resumes at the next PC.

Source files
------------

// File: rtl/sequence_ctrl.sv
// Hardwired control unit for the Mini SRC datapath: steps fetch, decode and execute
// for the supported ISA subset and drives every datapath strobe combinationally from the state.
module sequence_ctrl (
  input  logic        clock,
  input  logic        clear,
  input  logic        start,
  input  logic [31:0] ir,
  input  logic        con_ff,
  output logic        incPC,
  output logic        e_PC,
  output logic        e_IR,
  output logic        e_Y,
  output logic        e_Z,
  output logic        e_HI,
  output logic        e_LO,
  output logic        e_MDR,
  output logic        e_MAR,
  output logic        e_OutPort,
  output logic        e_InPort,
  output logic        e_RA,
  output logic        e_CON_FF,
  output logic        ram_read,
  output logic        ram_write,
  output logic        MDR_read,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        e_Rin,
  output logic        e_Rout,
  output logic        BAout,
  output logic        imm_sel,
  output logic [3:0]  ALU_op,
  output logic [4:0]  BusDataSelect,
  output logic        run,
  output logic        illegal
);

  typedef enum logic [3:0] {
    StIdle, StHalted, StF0, StF1, StF2, StF3, StDec,
    StE3, StE4, StE5, StE6, StE7, StE8
  } state_e;

  localparam logic [4:0] BusNone = 5'b00000;
  localparam logic [4:0] BusReg  = 5'b00001;
  localparam logic [4:0] BusZlo  = 5'b10011;
  localparam logic [4:0] BusPc   = 5'b10100;
  localparam logic [4:0] BusMdr  = 5'b10101;

  state_e state_q, state_d;

  logic [4:0] opcode;
  logic       is_ld, is_ldi, is_st, is_r, is_imm, is_br, is_jr, is_nop, is_halt, is_legal;
  logic [3:0] alu_exec;
  logic       exec_state;
  logic       unused_ir;

  assign opcode    = ir[31:27];
  assign unused_ir = ^ir[26:0];

  assign is_ld    = (opcode == 5'd0);
  assign is_ldi   = (opcode == 5'd1);
  assign is_st    = (opcode == 5'd2);
  assign is_r     = (opcode >= 5'd3) && (opcode <= 5'd11);
  assign is_imm   = (opcode >= 5'd12) && (opcode <= 5'd14);
  assign is_br    = (opcode == 5'd19);
  assign is_jr    = (opcode == 5'd20);
  assign is_nop   = (opcode == 5'd26);
  assign is_halt  = (opcode == 5'd27);
  assign is_legal = is_ld | is_ldi | is_st | is_r | is_imm | is_br | is_jr | is_nop | is_halt;

  // Address arithmetic (ld/ldi/st/br) and addi all use the add operation.
  always_comb begin
    alu_exec = 4'b0000;
    if (is_r)                                          alu_exec = ir[30:27];
    else if (is_ld || is_ldi || is_st || is_br || opcode == 5'd12) alu_exec = 4'b0011;
    else if (opcode == 5'd13)                          alu_exec = 4'b0101;
    else if (opcode == 5'd14)                          alu_exec = 4'b0110;
  end

  assign exec_state = (state_q >= StE3);

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle, StHalted: if (start) state_d = StF0;
      StF0: state_d = StF1;
      StF1: state_d = StF2;
      StF2: state_d = StF3;
      StF3: state_d = StDec;
      StDec: begin
        if (!is_legal || is_nop) state_d = StF0;
        else if (is_halt)        state_d = StHalted;
        else                     state_d = StE3;
      end
      StE3: state_d = is_jr ? StF0 : StE4;
      StE4: state_d = StE5;
      StE5: state_d = (is_ld || is_st || is_br) ? StE6 : StF0;
      StE6: state_d = (is_ld || is_st) ? StE7 : StF0;
      StE7: state_d = is_ld ? StE8 : StF0;
      StE8: state_d = StF0;
      default: state_d = StIdle;
    endcase
  end

  assign e_HI      = 1'b0;
  assign e_LO      = 1'b0;
  assign e_OutPort = 1'b0;
  assign e_InPort  = 1'b0;
  assign e_RA      = 1'b0;

  always_comb begin
    incPC         = 1'b0;
    e_PC          = 1'b0;
    e_IR          = 1'b0;
    e_Y           = 1'b0;
    e_Z           = 1'b0;
    e_MDR         = 1'b0;
    e_MAR         = 1'b0;
    e_CON_FF      = 1'b0;
    ram_read      = 1'b0;
    ram_write     = 1'b0;
    MDR_read      = 1'b0;
    Gra           = 1'b0;
    Grb           = 1'b0;
    Grc           = 1'b0;
    e_Rin         = 1'b0;
    e_Rout        = 1'b0;
    BAout         = 1'b0;
    imm_sel       = 1'b0;
    BusDataSelect = BusNone;
    ALU_op        = exec_state ? alu_exec : 4'b0000;
    run           = (state_q != StIdle) && (state_q != StHalted);
    illegal       = (state_q == StDec) && !is_legal;
    case (state_q)
      StF0: begin BusDataSelect = BusPc; e_MAR = 1'b1; incPC = 1'b1; end
      StF1: ram_read = 1'b1;
      StF2: begin MDR_read = 1'b1; e_MDR = 1'b1; end
      StF3: begin BusDataSelect = BusMdr; e_IR = 1'b1; end
      StE3: begin
        if (is_br || is_jr) begin
          Gra = 1'b1; e_Rout = 1'b1; BusDataSelect = BusReg;
          e_CON_FF = is_br;
          e_PC     = is_jr;
        end else if (is_ldi || is_ld || is_st) begin
          // Base of zero comes from R0 forced through BAout.
          Grb = 1'b1; BAout = 1'b1; e_Y = 1'b1;
        end else begin
          Grb = 1'b1; e_Rout = 1'b1; BusDataSelect = BusReg; e_Y = 1'b1;
        end
      end
      StE4: begin
        if (is_br)     begin BusDataSelect = BusPc; e_Y = 1'b1; end
        else if (is_r) begin Grc = 1'b1; e_Rout = 1'b1; BusDataSelect = BusReg; e_Z = 1'b1; end
        else           begin imm_sel = 1'b1; e_Z = 1'b1; end
      end
      StE5: begin
        if (is_br)               begin imm_sel = 1'b1; e_Z = 1'b1; end
        else if (is_ld || is_st) begin BusDataSelect = BusZlo; e_MAR = 1'b1; end
        else                     begin Gra = 1'b1; e_Rin = 1'b1; BusDataSelect = BusZlo; end
      end
      StE6: begin
        if (is_br) begin
          BusDataSelect = BusZlo; e_PC = con_ff;
        end else if (is_st) begin
          Gra = 1'b1; e_Rout = 1'b1; BusDataSelect = BusReg; e_MDR = 1'b1;
        end else begin
          ram_read = 1'b1;
        end
      end
      StE7: begin
        if (is_st) ram_write = 1'b1;
        else       begin MDR_read = 1'b1; e_MDR = 1'b1; end
      end
      StE8: begin BusDataSelect = BusMdr; Gra = 1'b1; e_Rin = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sequence_ctrl.sv
// Scoreboard bench for sequence_ctrl: random programs are expanded into per-cycle strobe
// expectations from the instruction timing tables, and a monitor compares every cycle.
module tb_sequence_ctrl;

  typedef struct packed {
    logic incpc, e_pc, e_ir, e_y, e_z, e_hi, e_lo, e_mdr, e_mar, e_out, e_in, e_ra, e_con;
    logic ram_read, ram_write, mdr_read;
    logic gra, grb, grc, e_rin, e_rout, baout, imm_sel;
    logic [3:0] alu;
    logic [4:0] bds;
    logic run, illegal;
  } ctl_t;

  typedef struct packed {
    logic [31:0] ins;
    logic        c;
  } instr_t;

  logic        clock = 1'b0;
  logic        clear, start, con_ff;
  logic [31:0] ir;
  logic incPC, e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR, e_MAR, e_OutPort, e_InPort, e_RA;
  logic e_CON_FF, ram_read, ram_write, MDR_read, Gra, Grb, Grc, e_Rin, e_Rout, BAout, imm_sel;
  logic [3:0] ALU_op;
  logic [4:0] BusDataSelect;
  logic run, illegal;

  int vectors = 0;
  int miscompares = 0;
  logic mon_en = 1'b0;
  ctl_t exp_q[$];
  instr_t prog_q[$];
  ctl_t dv, mon_e;

  always #5 clock = ~clock;

  sequence_ctrl dut (
    .clock(clock), .clear(clear), .start(start), .ir(ir), .con_ff(con_ff),
    .incPC(incPC), .e_PC(e_PC), .e_IR(e_IR), .e_Y(e_Y), .e_Z(e_Z), .e_HI(e_HI), .e_LO(e_LO),
    .e_MDR(e_MDR), .e_MAR(e_MAR), .e_OutPort(e_OutPort), .e_InPort(e_InPort), .e_RA(e_RA),
    .e_CON_FF(e_CON_FF), .ram_read(ram_read), .ram_write(ram_write), .MDR_read(MDR_read),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .e_Rin(e_Rin), .e_Rout(e_Rout), .BAout(BAout),
    .imm_sel(imm_sel), .ALU_op(ALU_op), .BusDataSelect(BusDataSelect), .run(run),
    .illegal(illegal)
  );

  always_comb begin
    dv = '0;
    dv.incpc = incPC;       dv.e_pc = e_PC;       dv.e_ir = e_IR;         dv.e_y = e_Y;
    dv.e_z = e_Z;           dv.e_hi = e_HI;       dv.e_lo = e_LO;         dv.e_mdr = e_MDR;
    dv.e_mar = e_MAR;       dv.e_out = e_OutPort; dv.e_in = e_InPort;     dv.e_ra = e_RA;
    dv.e_con = e_CON_FF;    dv.ram_read = ram_read; dv.ram_write = ram_write;
    dv.mdr_read = MDR_read; dv.gra = Gra;         dv.grb = Grb;           dv.grc = Grc;
    dv.e_rin = e_Rin;       dv.e_rout = e_Rout;   dv.baout = BAout;       dv.imm_sel = imm_sel;
    dv.alu = ALU_op;        dv.bds = BusDataSelect; dv.run = run;         dv.illegal = illegal;
  end

  task automatic chk(input string nm, input ctl_t got, input ctl_t exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, got, exp);
    end
  endtask

  // Cycles from F0 through the last execute state.
  function automatic int n_cycles(input logic [4:0] op);
    if (op == 5'd0)  return 11;
    if (op == 5'd2)  return 10;
    if (op == 5'd19) return 9;
    if (op == 5'd20) return 6;
    if (op == 5'd1 || (op >= 5'd3 && op <= 5'd14)) return 8;
    return 5;
  endfunction

  function automatic logic [3:0] alu_of(input logic [4:0] op);
    if (op >= 5'd3 && op <= 5'd11) return op[3:0];
    if (op <= 5'd2 || op == 5'd12 || op == 5'd19) return 4'b0011;
    if (op == 5'd13) return 4'b0101;
    if (op == 5'd14) return 4'b0110;
    return 4'b0000;
  endfunction

  // Expected strobes for cycle k (0 = F0) of an instruction.
  function automatic ctl_t cyc_exp(input logic [31:0] ins, input logic c, input int k);
    ctl_t v;
    logic [4:0] op;
    logic rt, imm, ld, st, br, jr, legal;
    int j;
    v = '0;
    v.run = 1'b1;
    op = ins[31:27];
    rt = op >= 5'd3 && op <= 5'd11;
    imm = op >= 5'd12 && op <= 5'd14;
    ld = op == 5'd0;
    st = op == 5'd2;
    br = op == 5'd19;
    jr = op == 5'd20;
    legal = op <= 5'd14 || op == 5'd19 || op == 5'd20 || op == 5'd26 || op == 5'd27;
    j = k - 5;
    if (k == 0) begin v.bds = 5'b10100; v.e_mar = 1; v.incpc = 1; end
    else if (k == 1) v.ram_read = 1;
    else if (k == 2) begin v.mdr_read = 1; v.e_mdr = 1; end
    else if (k == 3) begin v.bds = 5'b10101; v.e_ir = 1; end
    else if (k == 4) v.illegal = !legal;
    else begin
      v.alu = alu_of(op);
      if (br) begin
        if (j == 0) begin v.gra = 1; v.e_rout = 1; v.bds = 5'b00001; v.e_con = 1; end
        if (j == 1) begin v.bds = 5'b10100; v.e_y = 1; end
        if (j == 2) begin v.imm_sel = 1; v.e_z = 1; end
        if (j == 3) begin v.bds = 5'b10011; v.e_pc = c; end
      end else if (jr) begin
        v.gra = 1; v.e_rout = 1; v.bds = 5'b00001; v.e_pc = 1;
      end else begin
        if (j == 0) begin
          v.grb = 1; v.e_y = 1;
          if (rt || imm) begin v.e_rout = 1; v.bds = 5'b00001; end
          else v.baout = 1;
        end
        if (j == 1) begin
          v.e_z = 1;
          if (rt) begin v.grc = 1; v.e_rout = 1; v.bds = 5'b00001; end
          else v.imm_sel = 1;
        end
        if (j == 2) begin
          v.bds = 5'b10011;
          if (ld || st) v.e_mar = 1;
          else begin v.gra = 1; v.e_rin = 1; end
        end
        if (j == 3) begin
          if (ld) v.ram_read = 1;
          else begin v.gra = 1; v.e_rout = 1; v.bds = 5'b00001; v.e_mdr = 1; end
        end
        if (j == 4) begin
          if (ld) begin v.mdr_read = 1; v.e_mdr = 1; end
          else v.ram_write = 1;
        end
        if (j == 5) begin v.bds = 5'b10101; v.gra = 1; v.e_rin = 1; end
      end
    end
    return v;
  endfunction

  always @(negedge clock) begin
    if (mon_en && exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("seq", dv, mon_e);
    end
  end

  // Runs n random instructions followed by halt, playing the datapath's IR and CON roles.
  task automatic run_prog(input int n);
    instr_t p, cur;
    logic [31:0] r;
    logic [4:0] op;
    logic s_eir, s_econ, halting;
    int budget;
    for (int i = 0; i <= n; i++) begin
      r = $urandom;
      if (i == n) op = 5'd27;
      else begin
        op = 5'($urandom_range(0, 31));
        while (op == 5'd27) op = 5'($urandom_range(0, 31));
      end
      p.ins = {op, r[26:0]};
      p.c = 1'($urandom_range(0, 1));
      prog_q.push_back(p);
      for (int k = 0; k < n_cycles(op); k++) exp_q.push_back(cyc_exp(p.ins, p.c, k));
    end
    exp_q.push_back('0);
    exp_q.push_back('0);
    @(negedge clock); start = 1'b1;
    @(posedge clock); #1; start = 1'b0; mon_en = 1'b1;
    halting = 1'b0;
    budget = 0;
    cur = '0;
    while (exp_q.size() > 0 && budget < 4000) begin
      @(negedge clock);
      s_eir = e_IR;
      s_econ = e_CON_FF;
      @(posedge clock); #1;
      if (s_eir) begin
        if (prog_q.size() > 0) cur = prog_q.pop_front();
        else cur.ins = {5'd27, 27'd0};
        ir = cur.ins;
        if (cur.ins[31:27] == 5'd27) halting = 1'b1;
      end
      if (s_econ) con_ff = cur.c;
      start = halting ? 1'b0 : 1'($urandom_range(0, 1));
      budget++;
    end
    mon_en = 1'b0;
    start = 1'b0;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected cycles left, required 0", exp_q.size());
      exp_q.delete();
    end
    prog_q.delete();
  endtask

  initial begin
    ctl_t e;
    clear = 1'b0;
    start = 1'b0;
    con_ff = 1'b0;
    ir = $urandom;
    #3 chk("reset", dv, '0);
    @(negedge clock); clear = 1'b1;
    repeat (3) begin @(negedge clock); chk("idle_hold", dv, '0); end
    start = 1'b1;
    @(posedge clock); #1; start = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    e = '0; e.run = 1; e.mdr_read = 1; e.e_mdr = 1;
    chk("f2_before_reset", dv, e);
    clear = 1'b0;
    #1 chk("reset_mid_f2", dv, '0);
    clear = 1'b1;
    repeat (3) begin @(negedge clock); chk("idle_after_reset", dv, '0); end
    run_prog(25);
    run_prog(25);
    run_prog(15);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
